// File: rtl/ysyx_24100005_ifu_pkg.sv
// Shared definitions for the ysyx_24100005 fetch unit: FSM encoding,
// reset PC and the instruction-address-misaligned fault code.
package ysyx_24100005_defs;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // RISC-V mcause value for an instruction-address-misaligned exception
  localparam logic [3:0] EXC_INST_MISALIGNED = 4'd0;

  // Instruction word handed to decode when the fetch faults
  localparam logic [31:0] FAULT_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_24100005_Reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one outstanding imem fetch, result held for decode
// until accepted, PC redirects from execute cancel stale fetches.
module ysyx_24100005_ifu
  import ysyx_24100005_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output ifu_state_t  dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready (or
  // req and gnt) are both high at posedge clk; valid/req and their payload
  // never depend combinationally on ready/gnt and stay stable until taken.

  ifu_state_t  state, state_n;
  logic        drop, drop_n;
  logic [31:0] pc;
  logic        pc_wen;
  logic [31:0] pc_din;
  logic        lat_en;
  logic [31:0] lat_inst;
  logic        lat_err;
  logic        misaligned;

  ysyx_24100005_Reg #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .wen  (pc_wen),
    .din  (pc_din),
    .dout (pc)
  );

  assign misaligned = pc_misaligned(pc);

  always_comb begin
    state_n  = state;
    drop_n   = drop;
    pc_wen   = 1'b0;
    pc_din   = pc + 32'd4;
    lat_en   = 1'b0;
    lat_inst = imem_rdata;
    lat_err  = 1'b0;

    unique case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end

      S_REQ: begin
        if (redirect_valid) begin
          pc_wen = 1'b1;
          pc_din = redirect_pc;
          // A grant taken this cycle fetches the old PC; its data must be dropped.
          if (!misaligned && imem_gnt) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end else if (misaligned) begin
          lat_en   = 1'b1;
          lat_inst = FAULT_INST;
          lat_err  = 1'b1;
          state_n  = S_HOLD;
        end else if (imem_gnt) begin
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_wen = 1'b1;
          pc_din = redirect_pc;
          if (imem_rvalid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            lat_en  = 1'b1;
            state_n = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_wen  = 1'b1;
          pc_din  = redirect_pc;
          state_n = S_REQ;
        end else if (out_ready) begin
          pc_wen  = 1'b1;
          state_n = S_REQ;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      drop     <= 1'b0;
      out_inst <= 32'h0;
      out_pc   <= RESET_PC;
      out_err  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      if (lat_en) begin
        out_inst <= lat_inst;
        out_pc   <= pc;
        out_err  <= lat_err;
      end
    end
  end

  assign imem_req  = (state == S_REQ) && !misaligned;
  assign imem_addr = pc;
  assign out_valid = (state == S_HOLD);
  assign dbg_state = state;

endmodule

// File: doc/ysyx_24100005_ifu.md
# ysyx_24100005_ifu

Instruction fetch unit for the ysyx_24100005 RV32 core. Holds the architectural PC, fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake, and presents it, with its PC, to the decode/execute stage over a valid/ready handshake. Accepts PC redirects (jal/jalr/branch targets) from execute and discards stale in-flight fetches.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- clk  in  1  clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held with stable imem_addr until granted
- imem_addr  out  32  fetch address (= PC)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts instruction
- out_inst  out  32  instruction word
- out_pc  out  32  PC of out_inst
- out_err  out  1  instruction-address-misaligned fault for out_pc
- redirect_valid  in  1  execute redirects PC
- redirect_pc  in  32  new PC

## Operation
- States: IDLE, REQ, WAIT, HOLD. One outstanding fetch maximum.
- IDLE: entered on reset; imem_req=0, out_valid=0; next cycle -> REQ.
- REQ: if pc[1:0]!=0: no request; load out_inst=32'h0, out_pc=pc, out_err=1 -> HOLD. Else imem_req=1, imem_addr=pc; gnt -> WAIT, else stay.
- WAIT: on imem_rvalid: if drop=0, latch rdata into out_inst, out_pc=pc, out_err=0 -> HOLD; if drop=1, discard, clear drop -> REQ.
- HOLD: out_valid=1; out_valid&out_ready -> pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) -> REQ.
- Redirect (highest priority, any state except IDLE): pc<=redirect_pc.
  - REQ without gnt: stay REQ (new address next cycle).
  - REQ with gnt same cycle: granted fetch is stale -> WAIT with drop=1.
  - WAIT: set drop=1 (if rvalid same cycle: discard data -> REQ, drop=0).
  - HOLD: clear out_valid -> REQ; a same-cycle out_ready handshake is void (pc not incremented; decode qualifies with redirect).
- Redirect in IDLE is ignored.
- imem_rvalid outside WAIT is ignored.
- out_inst/out_pc/out_err stable throughout HOLD.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, drop=0, imem_req=0, out_valid=0, out_err=0, out_inst=0, out_pc=RESET_PC.
- First imem_req: second cycle after rst deasserts (IDLE, then REQ).
- rvalid honoured no earlier than the cycle after gnt.
- Best case 3 cycles/instruction: REQ(gnt), WAIT(rvalid), HOLD(ready).
- All outputs driven from registers/state only; no combinational in->out paths.
- rst mid-fetch: back to IDLE; memory is reset by the same rst, and late responses fall outside WAIT so are ignored.

## Structure
- Shared header/package ysyx_24100005_defs: state encoding, RESET_PC default, misaligned-fault code.
- PC kept in the existing ysyx_24100005_Reg (width 32, reset RESET_PC); FSM, drop flag and output latches are local.
- No other sub-modules.

## Test plan
- Reset, zero-wait memory (gnt with req, rvalid next cycle), out_ready=1: PCs 8000_0000, 8000_0004, 8000_0008 delivered every 3 cycles with matching rdata.
- gnt delayed 3 cycles, out_ready low 2 cycles in HOLD: imem_addr and out_* stable throughout; single PC increment per handshake.
- redirect_pc=8000_0100 in WAIT, rvalid 2 cycles later: response dropped, next imem_addr=8000_0100, no out_valid for old PC.
- Redirect coincident with gnt in REQ, and with rvalid in WAIT: stale data never reaches out_inst; next fetch at target.
- redirect_pc=8000_0102: no imem_req; out_valid=1, out_err=1, out_inst=0, out_pc=8000_0102.
- rst asserted in WAIT, rvalid arrives during/after: IDLE then fetch from RESET_PC; stale rvalid ignored.
